// File: rtl/dcm_lock_supervisor.sv
// DCM lock supervisor: pulses DCM RST, waits for a stable LOCKED, retries on timeout/loss, reports clk_ok.
// Optional build macro LOCK_LOSS_FILTER_EN: in RUNNING, lock loss needs 4 consecutive low cycles of locked_s.
module dcm_lock_supervisor #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 262144,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       retry_req,
    output logic       dcm_rst,
    output logic       clk_ok,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET_DCM   = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE_WAIT = 3'd2,
        ST_RUNNING     = 3'd3,
        ST_FAILED      = 3'd4
    } state_t;

    localparam int CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       MAX_R       = 8'(MAX_RETRIES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       retry_count_reg, retry_count_next;
    logic [1:0]       sync_reg;
    logic             locked_s;
    logic             run_loss;
    logic             take_retry;
    logic             dcm_rst_reg, clk_ok_reg, fail_reg;

    // LOCKED comes from the DCM's own timing domain; two flops before use
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], locked};
        end
    end

    assign locked_s = sync_reg[1];

`ifdef LOCK_LOSS_FILTER_EN
    logic [1:0] low_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_cnt_reg <= 2'd0;
        end else if (state_reg != ST_RUNNING || locked_s) begin
            low_cnt_reg <= 2'd0;
        end else if (low_cnt_reg != 2'd3) begin
            low_cnt_reg <= low_cnt_reg + 2'd1;
        end
    end

    // fourth consecutive low cycle counts as a real loss
    assign run_loss = !locked_s && (low_cnt_reg == 2'd3);
`else
    assign run_loss = !locked_s;
`endif

    always_comb begin
        state_next       = state_reg;
        retry_count_next = retry_count_reg;
        take_retry       = 1'b0;
        case (state_reg)
            ST_RESET_DCM: begin
                if (cnt_reg == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) state_next = ST_STABLE_WAIT;
                else if (cnt_reg == TIMEOUT_LAST) take_retry = 1'b1;
            end
            ST_STABLE_WAIT: begin
                if (!locked_s) state_next = ST_WAIT_LOCK;
                else if (cnt_reg == STABLE_LAST) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (run_loss) take_retry = 1'b1;
            end
            ST_FAILED: begin
                state_next = ST_FAILED;
            end
            default: state_next = ST_RESET_DCM;
        endcase

        if (take_retry) begin
            if (retry_count_reg == MAX_R) begin
                state_next = ST_FAILED;
            end else begin
                retry_count_next = retry_count_reg + 8'd1;
                state_next       = ST_RESET_DCM;
            end
        end

        // retry_req overrides every other transition, including a same-cycle timeout
        if (retry_req) begin
            state_next       = ST_RESET_DCM;
            retry_count_next = 8'd0;
        end

        cnt_next = (retry_req || state_next != state_reg) ? '0 : cnt_reg + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_RESET_DCM;
            cnt_reg         <= '0;
            retry_count_reg <= 8'd0;
            dcm_rst_reg     <= 1'b1;
            clk_ok_reg      <= 1'b0;
            fail_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            retry_count_reg <= retry_count_next;
            dcm_rst_reg     <= (state_next == ST_RESET_DCM) || (state_next == ST_FAILED);
            clk_ok_reg      <= (state_next == ST_RUNNING);
            fail_reg        <= (state_next == ST_FAILED);
        end
    end

    assign dcm_rst     = dcm_rst_reg;
    assign clk_ok      = clk_ok_reg;
    assign fail        = fail_reg;
    assign retry_count = retry_count_reg;
    assign state       = state_reg;

endmodule
